// File: rtl/iccm_stream_loader.sv
// Byte-stream to instruction-memory loader: packs UART bytes into DATA_W-bit words,
// writes them at incrementing addresses and releases the core on an end-of-image word.
module iccm_stream_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STEP   = 1,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter logic [31:0] EOF_WORD    = 32'h0000_0FFF,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] word_cnt_o,
  output logic              overflow_o,
  output logic              reset_o
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned IW = $clog2(NB);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DATA_W-1:0] EOF_W   = DATA_W'(EOF_WORD);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic [IW-1:0]     lane;
  logic [DATA_W-1:0] asm_word;

  // Byte position idx lands in lane NB-1-idx for big-endian packing.
  assign lane = BIG_ENDIAN ? (IW'(NB - 1) - idx_q) : idx_q;

  // Current partial word with the incoming byte merged into its lane.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign asm_word[8*gi +: 8] = (lane == IW'(gi)) ? rx_byte_i : buf_q[8*gi +: 8];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_dv_i) begin
          buf_d   = asm_word;
          idx_d   = IW'(1);
          tmo_d   = '0;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (rx_dv_i) begin
          buf_d = asm_word;
          tmo_d = '0;
          if (idx_q == IW'(NB - 1)) begin
            idx_d   = '0;
            wdata_d = asm_word;
            state_d = (asm_word == EOF_W) ? S_DONE : S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          // The partial word is abandoned; buf_q lanes are overwritten by the next word.
          if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            idx_d   = '0;
            tmo_d   = '0;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (gnt_i) begin
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          state_d = S_IDLE;
          if (rx_dv_i) begin
            buf_d   = asm_word;
            idx_d   = IW'(1);
            tmo_d   = '0;
            state_d = S_COLLECT;
          end
        end else if (rx_dv_i) begin
          ovf_d = 1'b1;
        end
      end

      S_DONE: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign we_o       = (state_q == S_WRITE);
  assign reset_o    = (state_q == S_DONE);
  assign busy_o     = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign word_cnt_o = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_iccm_stream_loader.sv
// Bench for iccm_stream_loader: four differently parameterised loaders share one byte
// stream; a word-level model per instance is compared against every cycle.
module tb_iccm_stream_loader;

  localparam int CFG_BE   [4] = '{1, 0, 1, 1};
  localparam int CFG_TMO  [4] = '{0, 0, 8, 0};
  localparam int CFG_BASE [4] = '{0, 0, 0, 14};
  localparam int CFG_STEP [4] = '{1, 1, 1, 2};
  localparam int CFG_AW   [4] = '{14, 14, 14, 4};

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       gnt;

  logic        we0, we1, we2, we3;
  logic [13:0] ad0, ad1, ad2;
  logic [3:0]  ad3;
  logic [31:0] wd0, wd1, wd2, wd3;
  logic        bz0, bz1, bz2, bz3;
  logic [13:0] cn0, cn1, cn2;
  logic [3:0]  cn3;
  logic        ov0, ov1, ov2, ov3;
  logic        rs0, rs1, rs2, rs3;

  logic        we_w [4];
  logic [13:0] ad_w [4];
  logic [31:0] wd_w [4];
  logic        bz_w [4];
  logic [13:0] cn_w [4];
  logic        ov_w [4];
  logic        rs_w [4];

  always_comb begin
    we_w = '{we0, we1, we2, we3};
    ad_w = '{ad0, ad1, ad2, {10'b0, ad3}};
    wd_w = '{wd0, wd1, wd2, wd3};
    bz_w = '{bz0, bz1, bz2, bz3};
    cn_w = '{cn0, cn1, cn2, {10'b0, cn3}};
    ov_w = '{ov0, ov1, ov2, ov3};
    rs_w = '{rs0, rs1, rs2, rs3};
  end

  iccm_stream_loader #(.DATA_W(32), .ADDR_W(14), .BASE_ADDR(0), .ADDR_STEP(1),
                       .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(0)) u_be (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte), .gnt_i(gnt),
    .we_o(we0), .addr_o(ad0), .wdata_o(wd0), .busy_o(bz0), .word_cnt_o(cn0),
    .overflow_o(ov0), .reset_o(rs0));

  iccm_stream_loader #(.DATA_W(32), .ADDR_W(14), .BASE_ADDR(0), .ADDR_STEP(1),
                       .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(0)) u_le (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte), .gnt_i(gnt),
    .we_o(we1), .addr_o(ad1), .wdata_o(wd1), .busy_o(bz1), .word_cnt_o(cn1),
    .overflow_o(ov1), .reset_o(rs1));

  iccm_stream_loader #(.DATA_W(32), .ADDR_W(14), .BASE_ADDR(0), .ADDR_STEP(1),
                       .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(8)) u_tmo (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte), .gnt_i(gnt),
    .we_o(we2), .addr_o(ad2), .wdata_o(wd2), .busy_o(bz2), .word_cnt_o(cn2),
    .overflow_o(ov2), .reset_o(rs2));

  iccm_stream_loader #(.DATA_W(32), .ADDR_W(4), .BASE_ADDR(14), .ADDR_STEP(2),
                       .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte), .gnt_i(gnt),
    .we_o(we3), .addr_o(ad3), .wdata_o(wd3), .busy_o(bz3), .word_cnt_o(cn3),
    .overflow_o(ov3), .reset_o(rs3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Word-level model state per instance.
  logic [7:0]  m_part  [4][4];
  int          m_np    [4];
  int          m_idle  [4];
  bit          m_pend  [4];
  bit          m_done  [4];
  bit          m_ovf   [4];
  int          m_addr  [4];
  int          m_cnt   [4];
  logic [31:0] m_wdata [4];

  // Writes observed at the DUT boundary (we_o & gnt_i at a clock edge).
  int          log_n [4];
  int          log_a [4][32];
  logic [31:0] log_d [4][32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] w;
    int amod;
    amod = 1 << CFG_AW[k];
    if (!rst_n) begin
      m_np[k] = 0; m_idle[k] = 0; m_pend[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
      m_addr[k] = CFG_BASE[k]; m_cnt[k] = 0; m_wdata[k] = '0;
      return;
    end
    if (m_done[k]) return;
    if (m_pend[k]) begin
      if (gnt) begin
        m_pend[k] = 0;
        m_addr[k] = (m_addr[k] + CFG_STEP[k]) % amod;
        if (m_cnt[k] < amod - 1) m_cnt[k]++;
        if (rx_dv) begin
          m_part[k][0] = rx_byte; m_np[k] = 1; m_idle[k] = 0;
        end
      end else if (rx_dv) begin
        m_ovf[k] = 1;
      end
      return;
    end
    if (rx_dv) begin
      m_part[k][m_np[k]] = rx_byte;
      m_np[k]++;
      m_idle[k] = 0;
      if (m_np[k] == 4) begin
        w = '0;
        for (int i = 0; i < 4; i++)
          w |= 32'(m_part[k][i]) << (CFG_BE[k] != 0 ? 8 * (3 - i) : 8 * i);
        m_np[k] = 0;
        m_wdata[k] = w;
        if (w == 32'h0000_0FFF) m_done[k] = 1;
        else m_pend[k] = 1;
      end
    end else if (m_np[k] > 0 && CFG_TMO[k] > 0) begin
      m_idle[k]++;
      if (m_idle[k] == CFG_TMO[k]) begin
        m_np[k] = 0; m_idle[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        log_n[k] = 0;
      end else if (we_w[k] && gnt && log_n[k] < 32) begin
        log_a[k][log_n[k]] = int'(ad_w[k]);
        log_d[k][log_n[k]] = wd_w[k];
        log_n[k]++;
        if (k == 0) $display("write inst0 addr=%0d data=%h", ad_w[k], wd_w[k]);
      end
      model_step(k);
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [51:0] act, exp;
      act = {we_w[k], ad_w[k], wd_w[k], bz_w[k], cn_w[k], ov_w[k], rs_w[k]};
      exp = {m_pend[k], 14'(m_addr[k]), m_wdata[k], (m_np[k] > 0) || m_pend[k],
             14'(m_cnt[k]), m_ovf[k], m_done[k]};
      n_checks++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cycle inst%0d t=%0t we/addr/wdata/busy/cnt/ovf/rst got %b/%0d/%h/%b/%0d/%b/%b expected %b/%0d/%h/%b/%0d/%b/%b",
                 k, $time, act[51], act[50:37], act[36:5], act[4], act[16:3] & 14'h0 | cn_w[k],
                 act[1], act[0], exp[51], exp[50:37], exp[36:5], exp[4], 14'(m_cnt[k]),
                 exp[1], exp[0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; gnt = 1'b1;
    idle(3);
    chk("rst_we", {31'b0, we0}, 32'd0);
    chk("rst_addr_base0", {18'b0, ad0}, 32'd0);
    chk("rst_addr_base14", {28'b0, ad3}, 32'd14);
    chk("rst_wdata", wd0, 32'h0);
    chk("rst_busy_cnt_ovf_rst", {28'b0, bz0, ov0, rs0, |cn0}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Single word, both byte orders, immediate grant.
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    chk("t1_we_latency", {31'b0, we0}, 32'd1);
    chk("t1_wdata_be", wd0, 32'h1234_5678);
    chk("t2_wdata_le", wd1, 32'h7856_3412);
    chk("t1_addr_during_write", {18'b0, ad0}, 32'd0);
    idle(2);
    chk("t1_addr_after", {18'b0, ad0}, 32'd1);
    chk("t1_cnt_after", {18'b0, cn0}, 32'd1);

    // Three words then end-of-image marker; later bytes are ignored.
    do_reset();
    send_word(32'h0102_0304); send_word(32'h0506_0708); send_word(32'h090A_0B0C);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h0F); send_byte(8'hFF);
    chk("t3_reset_o", {31'b0, rs0}, 32'd1);
    chk("t3_no_we", {31'b0, we0}, 32'd0);
    chk("t3_addr_hold", {18'b0, ad0}, 32'd3);
    send_word(32'h1122_3344);
    idle(2);
    chk("t3_nwrites", log_n[0], 32'd3);
    chk("t3_addr0", log_a[0][0], 32'd0);
    chk("t3_addr2", log_a[0][2], 32'd2);
    chk("t3_data2", log_d[0][2], 32'h090A_0B0C);
    chk("t3_le_not_eof", log_n[1], 32'd5);

    // Stalled write: byte arrives on the third stalled cycle.
    do_reset();
    gnt = 1'b0;
    send_word(32'hA1A2_A3A4);
    idle(2); send_byte(8'hEE); idle(2);
    chk("t4_we_held", {31'b0, we0}, 32'd1);
    chk("t4_addr_held", {18'b0, ad0}, 32'd0);
    chk("t4_data_held", wd0, 32'hA1A2_A3A4);
    chk("t4_overflow", {31'b0, ov0}, 32'd1);
    gnt = 1'b1;
    idle(2);
    chk("t4_written", log_n[0], 32'd1);
    chk("t4_data", log_d[0][0], 32'hA1A2_A3A4);
    chk("t4_overflow_sticky", {31'b0, ov0}, 32'd1);

    // Timeout: 7 idle cycles keeps the partial word, 8 drops it.
    do_reset();
    send_byte(8'h01); send_byte(8'h02); idle(7); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); idle(8);
    chk("t5_busy_dropped", {31'b0, bz2}, 32'd0);
    chk("t5_busy_no_tmo", {31'b0, bz0}, 32'd1);
    send_word(32'hAABB_CCDD);
    idle(2);
    chk("t5_nwrites", log_n[2], 32'd2);
    chk("t5_data0", log_d[2][0], 32'h0102_0304);
    chk("t5_data1", log_d[2][1], 32'hAABB_CCDD);
    chk("t5_addr1", log_a[2][1], 32'd1);

    // Address wrap with step 2 in a 4-bit space, then counter saturation.
    do_reset();
    for (int i = 0; i < 17; i++) send_word({8'h20 + 8'(i), 8'h01, 8'h02, 8'(i)});
    idle(2);
    chk("t6_wrap_a0", log_a[3][0], 32'd14);
    chk("t6_wrap_a1", log_a[3][1], 32'd0);
    chk("t6_cnt_sat", {28'b0, cn3}, 32'd15);
    chk("t6_cnt_17", {18'b0, cn0}, 32'd17);
    chk("t6_addr_end", {28'b0, ad3}, 32'd0);

    // Asynchronous reset in the middle of a word.
    send_byte(8'h55); send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    chk("t6_arst_busy", {31'b0, bz0}, 32'd0);
    chk("t6_arst_addr", {28'b0, ad3}, 32'd14);
    chk("t6_arst_cnt", {18'b0, cn0}, 32'd0);
    chk("t6_arst_wdata", wd0, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
